// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and helpers for the direct-mapped instruction cache
package icache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Extract `width` bits of an address starting at bit `lsb`.
  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb,
                                             input int width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + W'(1);
  end

endmodule

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped instruction cache with line refill, flush and perf counters
module icache_dm
  import icache_pkg::*;
#(
  parameter int DATA  = 32,
  parameter int ADDR  = 32,
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDR-1:0]  PC,
  input  logic             req,
  input  logic             flush,
  output logic [DATA-1:0]  RD,
  output logic             hit,
  output logic             stall,
  output logic             mem_req,
  output logic [ADDR-1:0]  mem_addr,
  input  logic [DATA-1:0]  mem_rdata,
  input  logic             mem_valid,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int OFF  = clog2(WORDS);
  localparam int IDX  = clog2(LINES);
  localparam int TAG  = ADDR - IDX - OFF - 2;
  localparam int LINE = ADDR - OFF - 2;

  logic [DATA-1:0] data_mem [LINES*WORDS];
  logic [TAG-1:0]  tag_mem  [LINES];
  logic [LINES-1:0] valid;

  state_t          state, state_n;
  logic [LINE-1:0] line_addr;
  logic [OFF-1:0]  wcnt;
  logic [OFF-1:0]  off;
  logic [IDX-1:0]  idx, ridx;
  logic [TAG-1:0]  tag, rtag;
  logic            miss_start;
  logic            word_we;

  assign off  = OFF'(addr_field(64'(PC), 2, OFF));
  assign idx  = IDX'(addr_field(64'(PC), OFF + 2, IDX));
  assign tag  = TAG'(addr_field(64'(PC), IDX + OFF + 2, TAG));
  assign ridx = line_addr[IDX-1:0];
  assign rtag = line_addr[LINE-1:IDX];

  assign RD  = data_mem[{idx, off}];
  assign hit = (state == IDLE) && req && valid[idx] && (tag_mem[idx] == tag);
  assign word_we = (state == REFILL) && mem_valid && !flush;

  always_comb begin
    state_n    = state;
    miss_start = 1'b0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          stall      = 1'b1;
          state_n    = REFILL;
          miss_start = 1'b1;
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {line_addr, wcnt, 2'b00};
        if (mem_valid && (wcnt == OFF'(WORDS - 1))) state_n = FILL_DONE;
      end
      FILL_DONE: begin
        stall   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Flush wins over everything but reset, including a miss detected this cycle.
    if (flush) begin
      state_n    = IDLE;
      miss_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      line_addr <= '0;
      wcnt      <= '0;
    end else begin
      state <= state_n;
      if (flush) valid <= '0;
      else if (state == FILL_DONE) valid[ridx] <= 1'b1;
      if (miss_start) begin
        line_addr <= PC[ADDR-1:OFF+2];
        wcnt      <= '0;
      end else if (word_we) begin
        wcnt <= wcnt + OFF'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_we) data_mem[{ridx, wcnt}] <= mem_rdata;
    if (state == FILL_DONE) tag_mem[ridx] <= rtag;
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .count (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_start),
    .count (miss_cnt)
  );

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - randomized and directed self-checking bench for icache_dm
module tb_icache_dm;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int LINE_BYTES = 4 * WORDS;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic        req;
  logic        flush;
  logic [31:0] RD;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_checks;
  int n_fail;

  // Reference state: which memory line each cache slot is believed to hold.
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  int unsigned m_hit;
  int unsigned m_miss;

  icache_dm #(.DATA(32), .ADDR(32), .LINES(LINES), .WORDS(WORDS), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .PC        (PC),
    .req       (req),
    .flush     (flush),
    .RD        (RD),
    .hit       (hit),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000 ^ (a >> 2);
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a / LINE_BYTES) % LINES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (LINE_BYTES * LINES);
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // mode 0: mem_valid always high, 1: every 3rd cycle, 2: random
  task automatic fetch(input logic [31:0] addr, input int mode);
    logic        exp_hit;
    logic        done;
    logic [31:0] base;
    int          k;
    int          cyc;
    exp_hit = m_valid[line_of(addr)] && (m_tag[line_of(addr)] == tag_of(addr));
    base = addr - (addr % LINE_BYTES);
    k = 0;
    done = 1'b0;
    PC = addr;
    req = 1'b1;
    for (cyc = 0; cyc < 200 && !done; cyc++) begin
      mem_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cyc == 0) chk("first_cycle_hit", 64'(hit), 64'(exp_hit));
      chk("stall_vs_hit", 64'(stall), 64'(!hit));
      if (mem_req) begin
        chk("mem_addr", 64'(mem_addr), 64'(base + 32'(4 * k)));
        if (mem_valid) k++;
      end
      if (hit) begin
        chk("rd", 64'(RD), 64'(mem_word({addr[31:2], 2'b00})));
        done = 1'b1;
      end
      next_cycle();
    end
    chk("fetch_completed", 64'(done), 64'd1);
    if (!exp_hit) begin
      chk("words_refilled", 64'(k), 64'(WORDS));
      if (mode == 0) chk("miss_latency", 64'(cyc - 1), 64'(WORDS + 2));
      m_miss++;
      m_valid[line_of(addr)] = 1'b1;
      m_tag[line_of(addr)] = tag_of(addr);
    end
    m_hit++;
    req = 1'b0;
    mem_valid = 1'b0;
    chk("hit_cnt", 64'(hit_cnt), 64'(m_hit));
    chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    m_hit = 0;
    m_miss = 0;
    model_clear();
    rst = 1'b1;
    PC = '0;
    req = 1'b0;
    flush = 1'b0;
    mem_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_hit", 64'(hit), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_hit_cnt", 64'(hit_cnt), 64'd0);
    chk("reset_miss_cnt", 64'(miss_cnt), 64'd0);
    next_cycle();

    // Cold miss, spatial hit, conflict eviction.
    fetch(32'h40, 0);
    fetch(32'h48, 0);
    fetch(32'h140, 0);
    fetch(32'h40, 0);
    chk("conflict_miss_cnt", 64'(miss_cnt), 64'd3);

    // Backpressured refill, then every offset of the line.
    fetch(32'h200, 1);
    for (int i = 1; i < WORDS; i++) fetch(32'h200 + 32'(4 * i), 0);

    // Flush during the second refill word.
    fetch(32'h50, 0);
    fetch(32'h140, 0);
    PC = 32'h40;
    req = 1'b1;
    mem_valid = 1'b1;
    @(negedge clk);
    chk("flush_pre_miss", 64'(stall), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("flush_word0_addr", 64'(mem_addr), 64'h40);
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_word1_addr", 64'(mem_addr), 64'h44);
    next_cycle();
    flush = 1'b0;
    req = 1'b0;
    mem_valid = 1'b0;
    m_miss++;
    model_clear();
    @(negedge clk);
    chk("flush_mem_req", 64'(mem_req), 64'd0);
    chk("flush_idle_stall", 64'(stall), 64'd0);
    next_cycle();
    fetch(32'h40, 0);
    fetch(32'h50, 0);

    // Flush coincident with a hit still returns the word.
    PC = 32'h54;
    req = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_hit", 64'(hit), 64'd1);
    chk("flush_hit_rd", 64'(RD), 64'(mem_word(32'h54)));
    next_cycle();
    flush = 1'b0;
    req = 1'b0;
    m_hit++;
    model_clear();
    fetch(32'h54, 0);

    // Randomized fetches over a pool larger than the cache.
    for (int i = 0; i < 40; i++) fetch(32'($urandom_range(0, 511)) * 32'd4, int'($urandom_range(0, 2)));

    // Reset in the middle of a refill.
    PC = 32'h12340;
    req = 1'b1;
    mem_valid = 1'b1;
    @(negedge clk);
    chk("rst_pre_miss", 64'(stall), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("rst_in_refill", 64'(mem_req), 64'd1);
    next_cycle();
    rst = 1'b1;
    req = 1'b0;
    next_cycle();
    rst = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall", 64'(stall), 64'd0);
    chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mid_hit_cnt", 64'(hit_cnt), 64'd0);
    chk("rst_mid_miss_cnt", 64'(miss_cnt), 64'd0);
    next_cycle();
    m_hit = 0;
    m_miss = 0;
    model_clear();
    fetch(32'h48, 0);
    chk("post_rst_miss_cnt", 64'(miss_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Parametrised direct-mapped instruction cache. Next generation of the single-cycle instruction memory.
- Sits between the core fetch stage (PC in, instruction out) and a slower backing instruction memory.
- Hits return the word combinationally in the same cycle.
- Misses stall fetch and refill one whole line over a valid-based word handshake.
- Adds flush support and hit/miss performance counters.

Parameters:
- DATA, 32, instruction word width in bits.
- ADDR, 32, byte-address width.
- LINES, 16, number of cache lines; power of two, at least 2.
- WORDS, 4, words per line; power of two, at least 2.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- PC  in  ADDR  fetch byte address; bits [1:0] are ignored.
- req  in  1  fetch request valid.
- flush  in  1  invalidate all lines (fence.i).
- RD  out  DATA  instruction word; valid only when hit=1.
- hit  out  1  req served this cycle.
- stall  out  1  req pending on a miss/refill; core must hold PC.
- mem_req  out  1  backing-memory word request.
- mem_addr  out  ADDR  word-aligned byte address of the requested word.
- mem_rdata  in  DATA  returned word.
- mem_valid  in  1  mem_rdata valid; consumes the current mem_req.
- hit_cnt  out  CNT_W  number of hit cycles, saturating.
- miss_cnt  out  CNT_W  number of misses (refills started), saturating.

Behaviour:
- Address split:
  - OFF = log2(WORDS), IDX = log2(LINES).
  - word offset = PC[OFF+1:2]; index = PC[IDX+OFF+1:OFF+2]; tag = PC[ADDR-1:IDX+OFF+2].
- Storage: data array LINES*WORDS x DATA, tag array, valid bit per line.
- Reset:
  - All valid bits cleared; FSM to IDLE.
  - Counters, word counter and miss-address latch set to 0.
  - hit=0, stall=0, mem_req=0, mem_addr=0.
  - RD is don't-care while hit=0.
- FSM states: IDLE, REFILL, FILL_DONE.
- IDLE:
  - hit = req & valid[index] & tag match, combinational. RD = data[index][offset].
  - On req and no hit: stall=1, latch the line base address, clear the word counter, go to REFILL, increment miss_cnt.
- REFILL:
  - stall=1, mem_req=1, mem_addr = line base + 4*wordcnt.
  - On mem_valid: write mem_rdata to data[index][wordcnt] and increment wordcnt.
  - When the last word (wordcnt = WORDS-1) is accepted, go to FILL_DONE.
  - mem_addr holds steady until mem_valid. Each mem_valid consumes exactly one word.
- FILL_DONE:
  - Write tag, set valid[index]; stall=1, mem_req=0; go to IDLE.
  - The next cycle hits if PC is unchanged.
- Cold-miss latency with mem_valid tied high: miss cycle + WORDS refill cycles + 1 FILL_DONE, so the hit arrives WORDS+2 cycles after the first request.
- The core must hold PC and req while stall=1. Dropping req mid-refill does not abort the refill.
- Flush:
  - Clears all valid bits next edge and forces IDLE; highest priority after rst.
  - Mid-refill: aborts the refill, drops mem_req next cycle, leaves the line invalid. The backing memory must tolerate a dropped request.
  - Flush in IDLE coincident with a hit: the hit still returns that cycle; the line is invalid afterwards.
- Counters:
  - hit_cnt increments on every cycle with hit=1.
  - miss_cnt increments on IDLE->REFILL.
  - Both saturate at all-ones; neither is cleared by flush.
- The core never writes the instruction space; writes come only from refill.

Decomposition:
- Package icache_pkg holds:
  - function clog2 for derived widths;
  - state enum {IDLE, REFILL, FILL_DONE};
  - field-extraction helpers.
- One natural sub-module: sat_counter (parametric width, inc, rst), instantiated twice.
- Data and tag arrays stay inline.

Test Plan:
- Cold miss, LINES=16, WORDS=4, mem_valid=1: rst, then req PC=0x40.
  - Required: stall=1, mem_addr sequence 0x40, 0x44, 0x48, 0x4C.
  - Required: hit=1 with RD=word@0x40 on the 6th cycle after the request; miss_cnt=1.
- Spatial hit: after the cold miss, PC=0x48 -> hit=1 same cycle, RD=word@0x48, hit_cnt increments.
- Conflict eviction: fill 0x40, then PC=0x140 (index 4, tag 1) -> miss and refill 0x140..0x14C.
  - Then PC=0x40 misses again; miss_cnt=3.
- Backpressure: mem_valid pulses every 3rd cycle.
  - Required: mem_addr is held until each mem_valid; exactly 4 words are written; RD is correct for all 4 offsets.
- Flush: flush asserted during the 2nd refill word.
  - Required: mem_req=0 next cycle, FSM in IDLE.
  - Same PC then misses and refills from 0x40; a previously valid line at index 5 also misses.
- Reset mid-refill: rst during REFILL.
  - Required: stall=0, mem_req=0, counters=0 next cycle; the first req afterwards misses.
